// File: rtl/ctu_can_tx_sched.sv
// rtl/ctu_can_tx_sched.sv - CAN frame TX sequencer driving the CAN core register port
// Loads the TX buffer, sets TX-ready, polls status and reports done/error/timeout/abort.
module ctu_can_tx_sched #(
  parameter logic [15:0] TXB_BASE    = 16'h0100,
  parameter logic [15:0] TXCMD_ADDR  = 16'h00E0,
  parameter logic [31:0] TXCMD_SET   = 32'h0000_0102,
  parameter logic [31:0] TXCMD_ABT   = 32'h0000_0104,
  parameter logic [15:0] TXSTAT_ADDR = 16'h00E4,
  parameter int          DONE_BIT    = 0,
  parameter int          ERR_BIT     = 1,
  parameter int          POLL_GAP    = 8,
  parameter int          TIMEOUT     = 65535
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [28:0] req_id,
  input  logic        req_ide,
  input  logic [3:0]  req_dlc,
  input  logic [63:0] req_data,
  input  logic        abort,
  output logic        done_valid,
  output logic [1:0]  done_status,
  output logic        busy,
  output logic [15:0] m_addr,
  output logic [31:0] m_wdata,
  output logic        m_cs,
  output logic        m_rd,
  output logic        m_wr,
  input  logic [31:0] m_rdata
);

  localparam int PW = (TIMEOUT  < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_W_FMT, S_W_ID, S_W_TSL, S_W_TSU, S_W_D1, S_W_D2,
    S_W_CMD, S_RD, S_RW, S_GAP, S_W_ABT, S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [28:0]   r_id;
  logic          r_ide;
  logic [3:0]    r_dlc;
  logic [63:0]   r_data;
  logic          r_abort;
  logic [PW-1:0] r_poll;
  logic [GW-1:0] r_gap;
  logic [1:0]    r_status;
  logic          w_accept;
  logic          w_abt;
  logic          w_st_done;
  logic          w_st_err;
  logic          w_unused_rdata;

  assign req_ready      = (r_state == S_IDLE) && PRESETn;
  assign w_accept       = req_valid && req_ready;
  assign w_abt          = r_abort || abort;
  assign w_st_done      = m_rdata[DONE_BIT];
  assign w_st_err       = m_rdata[ERR_BIT];
  assign w_unused_rdata = ^m_rdata;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_W_FMT;
      S_W_FMT: w_next = S_W_ID;
      S_W_ID:  w_next = S_W_TSL;
      S_W_TSL: w_next = S_W_TSU;
      S_W_TSU: w_next = (r_dlc == 4'd0) ? S_W_CMD : S_W_D1;
      S_W_D1:  w_next = (r_dlc <= 4'd4) ? S_W_CMD : S_W_D2;
      S_W_D2:  w_next = S_W_CMD;
      S_W_CMD: w_next = S_RD;
      S_RD:    w_next = S_RW;
      S_RW: begin
        if (w_st_done || w_st_err)             w_next = S_DONE;
        else if (w_abt)                        w_next = S_W_ABT;
        else if (r_poll == PW'(TIMEOUT))       w_next = S_DONE;
        else                                   w_next = S_GAP;
      end
      S_GAP:   if (r_gap == GW'(POLL_GAP - 1)) w_next = S_RD;
      S_W_ABT: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_id     <= '0;
      r_ide    <= 1'b0;
      r_dlc    <= '0;
      r_data   <= '0;
      r_abort  <= 1'b0;
      r_poll   <= '0;
      r_gap    <= '0;
      r_status <= '0;
    end else begin
      if (w_accept) begin
        r_id    <= req_id;
        r_ide   <= req_ide;
        r_dlc   <= (req_dlc > 4'd8) ? 4'd8 : req_dlc;
        r_data  <= req_data;
        r_abort <= 1'b0;
        r_poll  <= '0;
      end else if (r_state != S_IDLE && abort) begin
        r_abort <= 1'b1;
      end
      if (r_state == S_RD && r_poll != '1) r_poll <= r_poll + 1'b1;
      if (r_state == S_RW)  r_gap <= '0;
      if (r_state == S_GAP) r_gap <= r_gap + 1'b1;
      // Status is resolved in RW; the abort path overwrites it in W_ABT.
      if (r_state == S_RW)
        r_status <= w_st_done ? 2'b00 : (w_st_err ? 2'b01 : 2'b10);
      if (r_state == S_W_ABT) r_status <= 2'b11;
    end
  end

  always_comb begin
    m_addr      = '0;
    m_wdata     = '0;
    m_rd        = 1'b0;
    m_wr        = 1'b0;
    done_valid  = 1'b0;
    done_status = '0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_W_FMT: begin m_wr = 1'b1; m_addr = TXB_BASE;          m_wdata = {25'b0, r_ide, 2'b00, r_dlc}; end
      S_W_ID: begin
        m_wr    = 1'b1;
        m_addr  = TXB_BASE + 16'h0004;
        m_wdata = r_ide ? {3'b0, r_id} : {3'b0, r_id[10:0], 18'b0};
      end
      S_W_TSL: begin m_wr = 1'b1; m_addr = TXB_BASE + 16'h0008; end
      S_W_TSU: begin m_wr = 1'b1; m_addr = TXB_BASE + 16'h000C; end
      S_W_D1:  begin m_wr = 1'b1; m_addr = TXB_BASE + 16'h0010; m_wdata = r_data[31:0];  end
      S_W_D2:  begin m_wr = 1'b1; m_addr = TXB_BASE + 16'h0014; m_wdata = r_data[63:32]; end
      S_W_CMD: begin m_wr = 1'b1; m_addr = TXCMD_ADDR;          m_wdata = TXCMD_SET;     end
      S_RD:    begin m_rd = 1'b1; m_addr = TXSTAT_ADDR; end
      S_W_ABT: begin m_wr = 1'b1; m_addr = TXCMD_ADDR;          m_wdata = TXCMD_ABT;     end
      S_DONE:  begin done_valid = 1'b1; done_status = r_status; end
      default: ;
    endcase
    m_cs = m_rd || m_wr;
  end

endmodule

// File: tb/tb_ctu_can_tx_sched.sv
// tb/tb_ctu_can_tx_sched.sv - randomized bench with a per-frame timeline model of the TX sequencer
module tb_ctu_can_tx_sched;

  localparam int PG = 8;
  localparam int TO = 3;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [28:0] req_id = '0;
  logic        req_ide = 1'b0;
  logic [3:0]  req_dlc = '0;
  logic [63:0] req_data = '0;
  logic        abort = 1'b0;
  logic        done_valid;
  logic [1:0]  done_status;
  logic        busy;
  logic [15:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_cs, m_rd, m_wr;
  logic [31:0] m_rdata = '0;

  ctu_can_tx_sched #(.POLL_GAP(PG), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_ide(req_ide), .req_dlc(req_dlc), .req_data(req_data),
    .abort(abort),
    .done_valid(done_valid), .done_status(done_status), .busy(busy),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_cs(m_cs), .m_rd(m_rd), .m_wr(m_wr),
    .m_rdata(m_rdata)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic        rdy;
    logic        busy;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic        dv;
    logic [1:0]  ds;
  } out_t;

  out_t        exp_a [0:127];
  logic        ab_a  [0:127];
  logic [31:0] rd_a  [0:127];
  logic [31:0] st    [0:TO-1];
  int          flen;
  int          bi;
  out_t        cur;
  logic        chk_en = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  always @(negedge PCLK) begin
    out_t a;
    if (chk_en) begin
      a.rdy = req_ready; a.busy = busy; a.cs = m_cs; a.rd = m_rd; a.wr = m_wr;
      a.addr = m_addr; a.wdata = m_wdata; a.dv = done_valid;
      a.ds = cur.dv ? done_status : 2'b00;
      n_chk++;
      if (a !== cur) begin
        n_err++;
        $display("FAIL cycle_out @%0t: got rdy%b busy%b cs%b rd%b wr%b a%h d%h dv%b ds%h expected rdy%b busy%b cs%b rd%b wr%b a%h d%h dv%b ds%h",
                 $time, a.rdy, a.busy, a.cs, a.rd, a.wr, a.addr, a.wdata, a.dv, a.ds,
                 cur.rdy, cur.busy, cur.cs, cur.rd, cur.wr, cur.addr, cur.wdata, cur.dv, cur.ds);
      end
    end
  end

  task automatic push_wr(input logic [15:0] addr, input logic [31:0] data);
    bi++;
    exp_a[bi].cs = 1'b1; exp_a[bi].wr = 1'b1; exp_a[bi].addr = addr; exp_a[bi].wdata = data;
  endtask

  // Expected output per cycle offset from the accept cycle; uses st[] and ab_a[].
  task automatic build(input logic [28:0] id, input logic ide, input logic [3:0] dlc, input logic [63:0] data);
    int  bytes, t, k, dn;
    logic seen;
    bytes = (dlc > 8) ? 8 : int'(dlc);
    for (int j = 0; j < 128; j++) begin
      exp_a[j] = '0; exp_a[j].busy = 1'b1; rd_a[j] = $urandom;
    end
    exp_a[0] = '0; exp_a[0].rdy = 1'b1;
    bi = 0;
    push_wr(16'h0100, 32'(bytes) | (ide ? 32'h40 : 32'h0));
    push_wr(16'h0104, ide ? {3'b0, id} : ({21'b0, id[10:0]} << 18));
    push_wr(16'h0108, 32'h0);
    push_wr(16'h010C, 32'h0);
    if (bytes > 0) push_wr(16'h0110, data[31:0]);
    if (bytes > 4) push_wr(16'h0114, data[63:32]);
    push_wr(16'h00E0, 32'h102);
    t = bi + 1; k = 0; dn = 0;
    while (dn == 0) begin
      exp_a[t].cs = 1'b1; exp_a[t].rd = 1'b1; exp_a[t].addr = 16'h00E4;
      rd_a[t+1] = st[k];
      seen = 1'b0;
      for (int j = 1; j <= t + 1; j++) seen |= ab_a[j];
      if (st[k][0])      begin dn = t + 2; exp_a[dn].ds = 2'd0; end
      else if (st[k][1]) begin dn = t + 2; exp_a[dn].ds = 2'd1; end
      else if (seen) begin
        exp_a[t+2].cs = 1'b1; exp_a[t+2].wr = 1'b1;
        exp_a[t+2].addr = 16'h00E0; exp_a[t+2].wdata = 32'h104;
        dn = t + 3; exp_a[dn].ds = 2'd3;
      end
      else if (k + 1 == TO) begin dn = t + 2; exp_a[dn].ds = 2'd2; end
      else begin t = t + 2 + PG; k++; end
    end
    exp_a[dn].dv = 1'b1;
    flen = dn + 1;
  endtask

  task automatic set_req(input logic [28:0] id, input logic ide, input logic [3:0] dlc, input logic [63:0] data);
    req_id = id; req_ide = ide; req_dlc = dlc; req_data = data;
  endtask

  task automatic run_frame(input int stop);
    logic [28:0] id0; logic ide0; logic [3:0] dlc0; logic [63:0] d0;
    id0 = req_id; ide0 = req_ide; dlc0 = req_dlc; d0 = req_data;
    for (int off = 0; off < flen && off < stop; off++) begin
      @(posedge PCLK); #1;
      req_valid = (off == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (off == 0) set_req(id0, ide0, dlc0, d0);
      else set_req(29'($urandom), 1'($urandom), 4'($urandom), {$urandom, $urandom});
      abort   = ab_a[off];
      m_rdata = rd_a[off];
      cur     = exp_a[off];
      chk_en  = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK); #1;
      req_valid = 1'b0; abort = 1'($urandom); m_rdata = $urandom;
      cur = '0; cur.rdy = 1'b1; chk_en = 1'b1;
    end
  endtask

  task automatic clr_stim();
    for (int j = 0; j < 128; j++) ab_a[j] = 1'b0;
    for (int k = 0; k < TO; k++) st[k] = 32'h0;
  endtask

  task automatic rand_stim();
    int mode, p;
    clr_stim();
    for (int k = 0; k < TO; k++) begin
      p = $urandom_range(0, 9);
      st[k] = (p <= 5) ? 32'h0 : (p <= 7) ? 32'h1 : (p == 8) ? 32'h2 : 32'h3;
      st[k] |= ($urandom & 32'hFFFF_FFFC);
    end
    mode = $urandom_range(0, 5);
    if (mode == 1) ab_a[$urandom_range(1, 8)] = 1'b1;
    if (mode == 2) ab_a[$urandom_range(1, 40)] = 1'b1;
    if (mode == 3) for (int j = 1; j < 128; j++) ab_a[j] = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge PCLK);
    @(negedge PCLK); #1;
    check("reset_outputs", {req_ready, busy, m_cs, m_rd, m_wr, m_addr, m_wdata, done_valid, done_status}, 64'h0);
    PRESETn = 1'b1;
    #1;
    check("ready_after_reset", {63'h0, req_ready}, 64'h1);

    // 1: std ID, dlc 8
    clr_stim(); st[0] = 32'h1;
    set_req(29'h123, 1'b0, 4'd8, 64'h8877_6655_4433_2211);
    build(req_id, req_ide, req_dlc, req_data);
    check("m1_fmt", {32'h0, exp_a[1].wdata}, 64'h08);
    check("m1_id",  {32'h0, exp_a[2].wdata}, 64'h048C_0000);
    check("m1_d1",  {32'h0, exp_a[5].wdata}, 64'h4433_2211);
    check("m1_cmd", {16'h0, exp_a[7].addr, exp_a[7].wdata}, {16'h0, 16'h00E0, 32'h102});
    check("m1_rd",  {63'h0, exp_a[8].rd}, 64'h1);
    run_frame(999);

    // 2: dlc 0, done on first poll
    clr_stim(); st[0] = 32'h1;
    set_req(29'h7FF, 1'b0, 4'd0, 64'h0);
    build(req_id, req_ide, req_dlc, req_data);
    check("m2_len", 64'(flen), 64'd9);
    run_frame(999);

    // 3: ext ID, dlc clamp
    clr_stim(); st[0] = 32'h2;
    set_req(29'h1ABCDEF, 1'b1, 4'd12, 64'hDEAD_BEEF_CAFE_F00D);
    build(req_id, req_ide, req_dlc, req_data);
    check("m3_fmt", {32'h0, exp_a[1].wdata}, 64'h48);
    check("m3_id",  {32'h0, exp_a[2].wdata}, 64'h01AB_CDEF);
    run_frame(999);

    // 4: timeout
    clr_stim();
    set_req(29'h55, 1'b0, 4'd0, 64'h0);
    build(req_id, req_ide, req_dlc, req_data);
    check("m4_len", 64'(flen), 64'd29);
    check("m4_status", {62'h0, exp_a[28].ds}, 64'd2);
    run_frame(999);
    idle(2);

    // 5a: abort during W_ID
    clr_stim(); ab_a[2] = 1'b1;
    set_req(29'h66, 1'b0, 4'd0, 64'h0);
    build(req_id, req_ide, req_dlc, req_data);
    check("m5_abt", {32'h0, exp_a[8].wdata}, 64'h104);
    check("m5_status", {62'h0, exp_a[9].ds}, 64'd3);
    run_frame(999);

    // 5b: done wins over abort
    clr_stim(); ab_a[3] = 1'b1; st[0] = 32'h3;
    set_req(29'h77, 1'b0, 4'd1, 64'hAB);
    build(req_id, req_ide, req_dlc, req_data);
    run_frame(999);

    // 6: reset during GAP
    clr_stim();
    set_req(29'h88, 1'b0, 4'd0, 64'h0);
    build(req_id, req_ide, req_dlc, req_data);
    run_frame(9);
    @(negedge PCLK); #1;
    chk_en = 1'b0; req_valid = 1'b0; abort = 1'b0;
    PRESETn = 1'b0;
    #1;
    check("reset_mid_frame", {req_ready, busy, m_cs, m_rd, m_wr, m_addr, m_wdata, done_valid, done_status}, 64'h0);
    repeat (3) begin
      @(negedge PCLK);
      check("reset_no_done", {62'h0, done_valid, busy}, 64'h0);
    end
    PRESETn = 1'b1;
    clr_stim(); st[0] = 32'h1;
    set_req(29'h99, 1'b0, 4'd4, 64'h1234_5678);
    build(req_id, req_ide, req_dlc, req_data);
    run_frame(999);

    // Randomized frames
    for (int f = 0; f < 150; f++) begin
      rand_stim();
      set_req(29'($urandom), 1'($urandom), 4'($urandom), {$urandom, $urandom});
      build(req_id, req_ide, req_dlc, req_data);
      run_frame(999);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    @(posedge PCLK); #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
